// File: rtl/vend_ctrl_pkg.sv
// Shared types for the vending controller: one-hot FSM states and coin value decode.
package vend_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle     = 4'b0001,
        StCollect  = 4'b0010,
        StDispense = 4'b0100,
        StChange   = 4'b1000
    } vend_state_e;

    // Coin value in half-units: half=1, one=2, both in the same cycle=3.
    function automatic logic [1:0] coin_value(input logic half, input logic one);
        return {one, half};
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Change pulse generator: loads a count, then emits pulse/gap pairs until the count is spent.
module vend_change_gen #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             pulse_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        active_d = active_q;
        if (load_i) begin
            cnt_d    = count_i;
            active_d = 1'b1;
        end else if (active_q) begin
            if (pulse_q) begin
                if (cnt_q == '0) active_d = 1'b0;
            end else if (cnt_q != '0) begin
                pulse_d = 1'b1;
                cnt_d   = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            active_q <= active_d;
        end
    end

    assign pulse_o = pulse_q;
    // High during the final pulse of the train.
    assign done_o  = pulse_q && (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, dispenser req/ack handshake with timeout, change return.
module vend_ctrl
    import vend_ctrl_pkg::*;
#(
    parameter int unsigned PRICE    = 5,
    parameter int unsigned CREDIT_W = 4,
    parameter int unsigned ACK_TMO  = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                pi_money_half,
    input  logic                pi_money_one,
    input  logic                pi_cancel,
    input  logic                pi_disp_ack,
    output logic                po_disp_req,
    output logic                po_change,
    output logic [CREDIT_W-1:0] po_credit,
    output logic                po_busy,
    output logic                po_reject,
    output logic                po_fault
);

    localparam int unsigned TmoW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
    localparam logic [CREDIT_W-1:0] PriceC  = CREDIT_W'(PRICE);
    localparam logic [TmoW-1:0]     TmoLast = TmoW'(ACK_TMO - 1);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic                req_q, req_d;
    logic                fault_q, fault_d;
    logic                reject_q, reject_d;
    logic [CREDIT_W-1:0] coin_v, sum;
    logic                coin_any;
    logic                chg_load, chg_pulse, chg_done;

    assign coin_v   = CREDIT_W'(coin_value(pi_money_half, pi_money_one));
    assign coin_any = pi_money_half | pi_money_one;
    assign sum      = credit_q + coin_v;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        tmo_d    = tmo_q;
        req_d    = req_q;
        fault_d  = 1'b0;
        reject_d = 1'b0;
        chg_load = 1'b0;
        unique case (state_q)
            StIdle, StCollect: begin
                // A completing coin always vends; cancel only matters below price.
                if (sum >= PriceC) begin
                    state_d  = StDispense;
                    credit_d = sum - PriceC;
                    req_d    = 1'b1;
                    tmo_d    = '0;
                end else if (pi_cancel && sum != '0) begin
                    state_d  = StChange;
                    credit_d = sum;
                    chg_load = 1'b1;
                end else begin
                    state_d  = (sum != '0) ? StCollect : StIdle;
                    credit_d = sum;
                end
            end
            StDispense: begin
                reject_d = coin_any;
                if (pi_disp_ack) begin
                    req_d = 1'b0;
                    tmo_d = '0;
                    if (credit_q != '0) begin
                        state_d  = StChange;
                        chg_load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (tmo_q == TmoLast) begin
                    // Dispenser never answered: refund the price along with any change.
                    req_d    = 1'b0;
                    tmo_d    = '0;
                    fault_d  = 1'b1;
                    credit_d = credit_q + PriceC;
                    state_d  = StChange;
                    chg_load = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StChange: begin
                reject_d = coin_any;
                if (credit_q == '0) begin
                    state_d = StIdle;
                end else if (chg_pulse) begin
                    credit_d = credit_q - 1'b1;
                    if (chg_done) state_d = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                credit_d = '0;
                tmo_d    = '0;
                req_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= StIdle;
            credit_q <= '0;
            tmo_q    <= '0;
            req_q    <= 1'b0;
            fault_q  <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            tmo_q    <= tmo_d;
            req_q    <= req_d;
            fault_q  <= fault_d;
            reject_q <= reject_d;
        end
    end

    vend_change_gen #(
        .CNT_W (CREDIT_W)
    ) u_change_gen (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .load_i  (chg_load),
        .count_i (credit_d),
        .pulse_o (chg_pulse),
        .done_o  (chg_done)
    );

    assign po_disp_req = req_q;
    assign po_change   = chg_pulse && (state_q == StChange);
    assign po_credit   = credit_q;
    assign po_busy     = (state_q == StDispense) || (state_q == StChange);
    assign po_reject   = reject_q;
    assign po_fault    = fault_q;

endmodule
